// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: bundle of the issue and result signals between the EX/RR pipeline
// stages and the HI/LO multiply-divide unit.
//   start   - EX-stage issue strobe for an MD instruction
//   op      - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//   rs_val  - forwarded rs operand
//   rt_val  - forwarded rt operand
//   md_use  - RR-stage instruction is an MD instruction
//   busy    - multiply/divide in flight (registered)
//   stall   - stall request to the hazard unit
//   hi, lo  - architectural HI/LO registers
//   rd_data - MFHI/MFLO read value
// The master modport is the pipeline side; the slave modport is the unit.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output start, op, rs_val, rt_val, md_use,
    input  busy, stall, hi, lo, rd_data
  );

  modport slave (
    input  start, op, rs_val, rt_val, md_use,
    output busy, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle HI/LO multiply-divide controller.
// The product or quotient/remainder is computed when the instruction is
// accepted and held in a pending pair {ph,pl}; it is committed to HI/LO after
// MUL_LAT or DIV_LAT cycles, modelling the latency of the real datapath.
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   io    - mdu_ctrl_if.slave (issue operands, busy/stall, hi/lo, rd_data)
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  io
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] ph, ph_n, pl, pl_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic        busy_q, busy_n;
  logic        dz, dz_n;

  // Operand conditioning: even opcodes (MULT, DIV) are signed.
  logic               sgn;
  logic signed [32:0] a_ext, b_ext;
  logic signed [65:0] prod_full;
  logic [63:0]        prod;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  always_comb begin
    sgn       = ~io.op[0];
    a_ext     = {sgn & io.rs_val[31], io.rs_val};
    b_ext     = {sgn & io.rt_val[31], io.rt_val};
    prod_full = 66'(a_ext) * 66'(b_ext);
    prod      = prod_full[63:0];

    // Divide on magnitudes, then restore signs: the quotient truncates toward
    // zero and the remainder follows the dividend.
    a_neg   = sgn & io.rs_val[31];
    b_neg   = sgn & io.rt_val[31];
    a_mag   = a_neg ? (32'd0 - io.rs_val) : io.rs_val;
    b_mag   = b_neg ? (32'd0 - io.rt_val) : io.rt_val;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    pl_n    = pl;
    hi_n    = hi_q;
    lo_n    = lo_q;
    dz_n    = dz;
    unique case (state)
      IDLE: begin
        if (io.start) begin
          case (io.op)
            OP_MULT, OP_MULTU: begin
              state_n       = MUL;
              cnt_n         = MUL_CNT;
              {ph_n, pl_n}  = prod;
            end
            OP_DIV, OP_DIVU: begin
              state_n = DIV;
              cnt_n   = DIV_CNT;
              ph_n    = rem;
              pl_n    = quot;
              dz_n    = (io.rt_val == 32'd0);
            end
            OP_MTHI: hi_n = io.rs_val;
            OP_MTLO: lo_n = io.rs_val;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = IDLE;
          // A divide by zero runs its full latency but leaves HI/LO alone.
          if (!(state == DIV && dz)) begin
            hi_n = ph;
            lo_n = pl;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ph     <= '0;
      pl     <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ph     <= ph_n;
      pl     <= pl_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      busy_q <= busy_n;
      dz     <= dz_n;
    end
  end

  // Stall also covers the issue cycle so a back-to-back MD instruction in RR
  // waits; busy is held low in reset, which yields the reset-time behaviour.
  always_comb begin
    io.stall = io.md_use & (busy_q | (io.start & ~io.op[2]));
    case (io.op)
      OP_MFHI: io.rd_data = hi_q;
      OP_MFLO: io.rd_data = lo_q;
      default: io.rd_data = '0;
    endcase
  end

  assign io.busy = busy_q;
  assign io.hi   = hi_q;
  assign io.lo   = lo_q;

endmodule
